// File: rtl/energy_detect_pkg.sv
// rtl/energy_detect_pkg.sv - shared state encoding and width defaults for the energy detector
//
// Purpose: state encoding for energy_detect_ctrl, default magnitude/window
//          widths and the derivation of the window-sum width.
// Ports:   none (package).
package energy_detect_pkg;

  localparam int unsigned MAG_W_DEF    = 17;
  localparam int unsigned WIN_LOG2_DEF = 4;

  // A sum of 2^win_log2 values of mag_w bits needs win_log2 extra bits.
  function automatic int unsigned acc_width(input int unsigned mag_w,
                                            input int unsigned win_log2);
    return mag_w + win_log2;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_SEARCH  = 3'd2,
    ST_CONFIRM = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

endpackage

// File: rtl/energy_window_sum.sv
// rtl/energy_window_sum.sv - sliding-window magnitude sum with delay line and fill tracking
//
// Purpose: keeps the last 2^WIN_LOG2 magnitudes and their running sum.
// Ports:
//   Clk, Rst_n     clock, asynchronous active-low reset
//   clear_i        synchronous clear of sum, delay line and fill counter
//   valid_i        accept magnitude_i this cycle
//   magnitude_i    incoming |A|^2 sample
//   sum_next_o     sum including magnitude_i, excluding the oldest sample
//   sum_o          registered running sum
//   fill_last_o    valid_i carries the sample that completes the first window
module energy_window_sum #(
  parameter int unsigned MAG_W    = 17,
  parameter int unsigned WIN_LOG2 = 4,
  parameter int unsigned ACC_W    = MAG_W + WIN_LOG2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [MAG_W-1:0] magnitude_i,
  output logic [ACC_W-1:0] sum_next_o,
  output logic [ACC_W-1:0] sum_o,
  output logic             fill_last_o
);

  localparam int WIN = 1 << WIN_LOG2;
  localparam logic [WIN_LOG2:0] FILL_LAST = (WIN_LOG2 + 1)'(WIN - 1);

  logic [MAG_W-1:0]  dl_q [WIN];
  logic [ACC_W-1:0]  sum_q;
  // MSB set means the window is full; the counter saturates there.
  logic [WIN_LOG2:0] fill_cnt_q;

  // The sum never exceeds WIN * (2^MAG_W - 1), so ACC_W bits cannot wrap.
  assign sum_next_o  = sum_q + ACC_W'(magnitude_i) - ACC_W'(dl_q[WIN-1]);
  assign sum_o       = sum_q;
  assign fill_last_o = valid_i && (fill_cnt_q == FILL_LAST);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sum_q      <= '0;
      fill_cnt_q <= '0;
      for (int i = 0; i < WIN; i++) dl_q[i] <= '0;
    end else if (clear_i) begin
      sum_q      <= '0;
      fill_cnt_q <= '0;
      for (int i = 0; i < WIN; i++) dl_q[i] <= '0;
    end else if (valid_i) begin
      sum_q   <= sum_next_o;
      dl_q[0] <= magnitude_i;
      for (int i = 1; i < WIN; i++) dl_q[i] <= dl_q[i-1];
      if (!fill_cnt_q[WIN_LOG2]) fill_cnt_q <= fill_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/energy_detect_ctrl.sv
// rtl/energy_detect_ctrl.sv - energy detection sequencer with confirm/hold FSM
//
// Purpose: gates samples into the energy block, sums its magnitude stream over
//          a sliding window, and pulses Detected after CONFIRM_CNT consecutive
//          window sums at or above Threshold, then ignores HOLD_LEN samples.
// Optional: define ENERGY_DETECT_PEAK_EN to track the peak window sum on
//           PeakEnergy; otherwise PeakEnergy is 0.
// Ports:
//   Clk, Rst_n      clock, asynchronous active-low reset
//   Start, Abort    arm pulse, synchronous abort (Abort wins)
//   SampleValid     sample-buffer valid; EnergyEnable = SampleValid while busy
//   MagValid        magnitude valid from the energy block
//   Magnitude       |A|^2 sample
//   Threshold       detection threshold on the window sum
//   Detected        one-cycle detection pulse
//   Busy, State     activity flag and state encoding
//   WindowEnergy    registered window sum
//   PeakEnergy      peak window sum (optional)
module energy_detect_ctrl
  import energy_detect_pkg::*;
#(
  parameter int unsigned WIN_LOG2    = WIN_LOG2_DEF,
  parameter int unsigned CONFIRM_CNT = 8,
  parameter int unsigned HOLD_LEN    = 320,
  parameter int unsigned MAG_W       = MAG_W_DEF,
  parameter int unsigned ACC_W       = acc_width(MAG_W, WIN_LOG2)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Abort,
  input  logic             SampleValid,
  output logic             EnergyEnable,
  input  logic             MagValid,
  input  logic [MAG_W-1:0] Magnitude,
  input  logic [ACC_W-1:0] Threshold,
  output logic             Detected,
  output logic             Busy,
  output logic [ACC_W-1:0] WindowEnergy,
  output logic [2:0]       State,
  output logic [ACC_W-1:0] PeakEnergy
);

  localparam int unsigned CNT_W  = $clog2(CONFIRM_CNT + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_LEN + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              det_q, det_d;

  logic              win_clear, win_valid, fill_last, above;
  logic [ACC_W-1:0]  sum_next, sum_reg;

  assign win_valid = MagValid && (state_q != ST_IDLE);
  assign win_clear = (state_q == ST_IDLE) && Start && !Abort;
  assign above     = (sum_next >= Threshold);

  energy_window_sum #(
    .MAG_W    (MAG_W),
    .WIN_LOG2 (WIN_LOG2),
    .ACC_W    (ACC_W)
  ) u_win (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .clear_i     (win_clear),
    .valid_i     (win_valid),
    .magnitude_i (Magnitude),
    .sum_next_o  (sum_next),
    .sum_o       (sum_reg),
    .fill_last_o (fill_last)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    det_d   = 1'b0;
    if (Abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_d = ST_FILL;
            cnt_d   = '0;
            hold_d  = '0;
          end
        end
        ST_FILL: begin
          if (fill_last) state_d = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (MagValid && above) begin
            // A single-sample confirm detects on the entry sample itself.
            if (CONFIRM_CNT == 1) begin
              det_d   = 1'b1;
              state_d = ST_HOLD;
              cnt_d   = '0;
              hold_d  = '0;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (MagValid) begin
            if (above) begin
              if (cnt_q == CNT_W'(CONFIRM_CNT - 1)) begin
                det_d   = 1'b1;
                state_d = ST_HOLD;
                cnt_d   = '0;
                hold_d  = '0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end else begin
              cnt_d   = '0;
              state_d = ST_SEARCH;
            end
          end
        end
        ST_HOLD: begin
          if (MagValid) begin
            if (hold_q == HOLD_W'(HOLD_LEN - 1)) begin
              state_d = ST_IDLE;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      det_q   <= det_d;
    end
  end

`ifdef ENERGY_DETECT_PEAK_EN
  logic [ACC_W-1:0] peak_q;
  logic             peak_upd;

  assign peak_upd = MagValid && (sum_next > peak_q) &&
                    ((state_q == ST_SEARCH) || (state_q == ST_CONFIRM) ||
                     (state_q == ST_HOLD));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)        peak_q <= '0;
    else if (win_clear) peak_q <= '0;
    else if (peak_upd)  peak_q <= sum_next;
  end

  assign PeakEnergy = peak_q;
`else
  assign PeakEnergy = '0;
`endif

  assign EnergyEnable = SampleValid && (state_q != ST_IDLE);
  assign Busy         = (state_q != ST_IDLE);
  assign State        = state_q;
  assign Detected     = det_q;
  assign WindowEnergy = sum_reg;

endmodule

// File: tb/tb_energy_detect_ctrl.sv
// tb/tb_energy_detect_ctrl.sv - self-checking bench for energy_detect_ctrl
module tb_energy_detect_ctrl;

  localparam int WIN     = 16;
  localparam int CONFIRM = 8;
  localparam int HOLD    = 320;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, sv = 1'b0, mv = 1'b0;
  logic [16:0] mag = '0;
  logic [20:0] thr = '0;
  logic        ee, det, busy;
  logic [20:0] win_e, peak_e;
  logic [2:0]  st;

  int errors = 0;
  int checks = 0;

  energy_detect_ctrl dut (
    .Clk          (clk),
    .Rst_n        (rst_n),
    .Start        (start),
    .Abort        (abort),
    .SampleValid  (sv),
    .EnergyEnable (ee),
    .MagValid     (mv),
    .Magnitude    (mag),
    .Threshold    (thr),
    .Detected     (det),
    .Busy         (busy),
    .WindowEnergy (win_e),
    .State        (st),
    .PeakEnergy   (peak_e)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: window is a queue of the last 16 samples, newest first,
  // and its energy is recomputed as a plain sum every sample.
  int q[$];
  int m_state, m_win, m_peak, m_fill, m_cnt, m_hold, m_samples;
  bit m_det;

  task automatic model_reset();
    q.delete();
    m_state = 0; m_win = 0; m_peak = 0; m_fill = 0;
    m_cnt = 0; m_hold = 0; m_samples = 0; m_det = 0;
  endtask

  task automatic model_step();
    int s;
    m_det = 0;
    if (m_state == 0) begin
      if (start && !abort) begin
        m_state = 1;
        q.delete();
        repeat (WIN) q.push_back(0);
        m_win = 0; m_fill = 0; m_cnt = 0; m_hold = 0; m_peak = 0; m_samples = 0;
      end
    end else begin
      s = m_win;
      if (mv) begin
        q.push_front(int'(mag));
        void'(q.pop_back());
        s = 0;
        foreach (q[i]) s += q[i];
        m_samples++;
        if (m_state >= 2 && s > m_peak) m_peak = s;
      end
      if (abort) begin
        m_state = 0; m_cnt = 0; m_hold = 0;
      end else if (mv) begin
        case (m_state)
          1: begin m_fill++; if (m_fill == WIN) m_state = 2; end
          2, 3: begin
            if (s >= int'(thr)) begin
              m_cnt = (m_state == 2) ? 1 : m_cnt + 1;
              m_state = 3;
              if (m_cnt == CONFIRM) begin
                m_det = 1; m_state = 4; m_cnt = 0; m_hold = 0;
              end
            end else begin
              m_cnt = 0; m_state = 2;
            end
          end
          4: begin m_hold++; if (m_hold == HOLD) m_state = 0; end
          default: m_state = 0;
        endcase
      end
      m_win = s;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  bit cmp_on = 0;
  int det_idx = -1;
  int det_cnt = 0;

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("State", st, m_state);
      chk("Busy", busy, m_state != 0);
      chk("Detected", det, m_det);
      chk("WindowEnergy", win_e, m_win);
      chk("EnergyEnable", ee, sv && (m_state != 0));
`ifdef ENERGY_DETECT_PEAK_EN
      chk("PeakEnergy", peak_e, m_peak);
`else
      chk("PeakEnergy", peak_e, 0);
`endif
      if (det === 1'b1) begin
        det_idx = m_samples;
        det_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int m, input bit gap);
    if (gap) begin
      while ($urandom_range(1, 0) == 1) begin
        sv = $urandom_range(1, 0);
        mv = 1'b0;
        tick();
      end
    end
    sv = 1'b1; mv = 1'b1; mag = 17'(m);
    tick();
    sv = 1'b0; mv = 1'b0;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Fill with 10s, then 100s until detection on the 17th hundred (sample 33).
  task automatic detect_run(input bit gap);
    thr = 21'd1000;
    det_idx = -1;
    arm();
    chk("fill_state", st, 1);
    for (int i = 0; i < WIN; i++) send(10, gap);
    chk("search_state", st, 2);
    chk("fill_sum", win_e, 160);
    for (int i = 0; i < 9; i++) send(100, gap);
    chk("below_thr_state", st, 2);
    send(100, gap);
    chk("confirm_entry", st, 3);
    chk("confirm_sum", win_e, 1060);
    for (int i = 0; i < 7; i++) send(100, gap);
    chk("hold_state", st, 4);
    #4;
    chk("det_index", det_idx, 33);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_state", st, 0);
    chk("rst_win", win_e, 0);
    chk("rst_peak", peak_e, 0);
    chk("rst_det", det, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    cmp_on = 1;
    sv = 1'b1;
    repeat (3) tick();
    chk("idle_ee", ee, 0);
    sv = 1'b0;

    // detection, pulse width and hold length
    detect_run(1'b0);
    chk("det_pulse", det, 1);
    tick();
    chk("det_once", det, 0);
    for (int i = 0; i < HOLD - 1; i++) send(100, 1'b0);
    chk("hold_end_minus1", st, 4);
    send(100, 1'b0);
    chk("hold_done_state", st, 0);
    chk("hold_done_busy", busy, 0);

    // gapped valid gives the same detection index
    detect_run(1'b1);
    do_abort();

    // confirm drop-out and counter restart
    det_cnt = 0;
    thr = 21'd1000;
    arm();
    for (int i = 0; i < WIN; i++) send(0, 1'b0);
    send(1000, 1'b0);
    chk("drop_confirm", st, 3);
    thr = 21'd1001;
    send(0, 1'b0);
    chk("drop_search", st, 2);
    thr = 21'd1000;
    send(0, 1'b0);
    for (int i = 0; i < CONFIRM - 2; i++) send(0, 1'b0);
    chk("drop_cnt_restart", st, 3);
    chk("drop_no_det", det_cnt, 0);
    send(0, 1'b0);
    chk("drop_redetect", st, 4);
    do_abort();

    // threshold zero: first SEARCH sample confirms
    thr = 21'd0;
    arm();
    for (int i = 0; i < WIN + 1; i++) send(0, 1'b0);
    chk("thr0_confirm", st, 3);
    do_abort();

    // Abort and Start together in HOLD
    detect_run(1'b0);
    for (int i = 0; i < 5; i++) send(200, 1'b0);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_start_idle", st, 0);
    arm();
    chk("rearm_fill", st, 1);
    chk("rearm_win", win_e, 0);
    chk("rearm_peak", peak_e, 0);
    do_abort();

    // randomized episodes
    for (int ep = 0; ep < 12; ep++) begin
      thr = (ep == 0) ? 21'd0 : 21'($urandom_range(4000, 0));
      arm();
      for (int c = 0; c < 1500 && (c < 3 || m_state != 0); c++) begin
        sv    = $urandom_range(1, 0);
        mv    = $urandom_range(1, 0);
        mag   = ($urandom_range(15, 0) == 0) ? 17'($urandom_range(65535, 0))
                                             : 17'($urandom_range(400, 0));
        abort = ($urandom_range(999, 0) == 0);
        start = ($urandom_range(99, 0) == 0);
        if ($urandom_range(199, 0) == 0) thr = 21'($urandom_range(4000, 0));
        tick();
      end
      mv = 1'b0; sv = 1'b0; start = 1'b0;
      do_abort();
    end

    // asynchronous reset in mid-stream
    thr = 21'd500;
    arm();
    for (int i = 0; i < 20; i++) send(300, 1'b0);
    sv = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", st, 0);
    chk("async_rst_win", win_e, 0);
    chk("async_rst_peak", peak_e, 0);
    chk("async_rst_ee", ee, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_ee", ee, 0);
    sv = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/energy_detect_ctrl.md
Name: energy_detect_ctrl

Overview:
- Sequencing controller for the RX energy datapath: gates sample flow into the energy-computing block and consumes its per-sample |A|² stream.
- Keeps a sliding-window energy sum, compares it against a programmable threshold, and runs a confirm/hold state machine.
- Emits a one-cycle Detected pulse toward the OFDM frame-sync logic.
- Sits between the sample buffer and the energy-computing block.

Parameters:
- WIN_LOG2, 4, log2 of window length in samples (window = 16)
- CONFIRM_CNT, 8, consecutive above-threshold window sums required for detection
- HOLD_LEN, 320, valid samples ignored after detection before returning to IDLE
- MAG_W, 17, width of the incoming magnitude
- ACC_W, MAG_W+WIN_LOG2, width of the window sum and threshold

Ports:
- Clk  in  1  clock
- Rst_n  in  1  asynchronous active-low reset
- Start  in  1  arm pulse
- Abort  in  1  synchronous abort to IDLE
- SampleValid  in  1  sample-buffer data valid
- EnergyEnable  out  1  InputEnable to the energy block
- MagValid  in  1  OutputEnable from the energy block
- Magnitude  in  MAG_W  DataMagnitude from the energy block; non-negative, bit 16 always 0
- Threshold  in  ACC_W  unsigned detection threshold, sampled every compare
- Detected  out  1  one-cycle detection pulse
- Busy  out  1  state != IDLE
- WindowEnergy  out  ACC_W  registered running window sum
- State  out  3  current state encoding
- PeakEnergy  out  ACC_W  peak window sum (see Optional Feature)

Behaviour:
- Reset values: state IDLE; all outputs 0, including WindowEnergy, PeakEnergy and internal counters. The delay line clears to 0.
- EnergyEnable is combinational: SampleValid && state != IDLE.
- Window arithmetic:
  - On each MagValid in a non-IDLE state: sum_next = sum + Magnitude − oldest, computed unsigned in ACC_W bits, with no overflow possible.
  - The delay line shifts in Magnitude, and WindowEnergy = sum_next on the next cycle.
  - MagValid while IDLE is ignored.
- States, encoding 0–4:
  - IDLE (0): Start → FILL. Entering FILL clears the sum, the delay line and the fill counter in the same edge.
  - FILL (1): counts 2^WIN_LOG2 MagValid samples → SEARCH. No compare in this state.
  - SEARCH (2): on MagValid with sum_next >= Threshold → CONFIRM with cnt=1.
  - CONFIRM (3): on MagValid:
    - sum_next >= Threshold: cnt++.
    - When cnt reaches CONFIRM_CNT: Detected=1 for one cycle (the cycle after that MagValid), then → HOLD.
    - sum_next < Threshold: cnt=0 → SEARCH.
  - HOLD (4): counts HOLD_LEN MagValid samples; the window keeps updating. At terminal count → IDLE.
- Counters advance only on MagValid; gaps of any length are allowed.
- Start while not IDLE is ignored.
- Abort in any state → IDLE next edge; it clears cnt and the hold counter, and any pending Detected is suppressed. Abort wins over simultaneous Start.
- Threshold = 0: the first SEARCH sample enters CONFIRM.
- CONFIRM_CNT = 1: detection occurs on the SEARCH→CONFIRM sample. Detected is pulsed on that cycle and the next state is HOLD.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro ENERGY_DETECT_PEAK_EN.
- Defined:
  - PeakEnergy tracks the max of sum_next across SEARCH, CONFIRM and HOLD.
  - It is cleared on entering FILL and held while IDLE.
- Undefined: PeakEnergy tied to 0 and no comparator is synthesized.

Decomposition:
- Package energy_detect_pkg holds:
  - state encoding constants IDLE..HOLD;
  - default MAG_W and WIN_LOG2;
  - ACC_W derivation.
- Sub-module energy_window_sum holds:
  - the delay line, running sum and fill flag;
  - inputs: clear, valid, magnitude;
  - outputs: sum_next, registered sum.
- The FSM, counters and peak logic stay in the top.

Test Plan:
- Reset check: assert Rst_n=0 mid-stream → all outputs 0 and State=0 asynchronously. Release, with no Start → EnergyEnable=0 regardless of SampleValid.
- Fill/search with defaults (WIN=16, Threshold=1000): Start, then 16 valid samples of Magnitude=10 → State 1→2 after the 16th. WindowEnergy=160; remain in SEARCH with Detected=0.
- Detection: continue with Magnitude=100.
  - The 10th sample gives sum 1060 → CONFIRM.
  - The 17th sample gives cnt=8 → Detected pulses for exactly 1 cycle, State=4.
  - After 320 further MagValid → State=0, Busy=0.
- Confirm drop-out: in CONFIRM after 5 samples of 100, feed Magnitude=0 until the sum falls below 1000 → back to SEARCH with cnt reset. No Detected is ever pulsed.
- Abort/Start collision: Abort=1 and Start=1 in the same cycle during HOLD → IDLE. The next Start begins FILL with WindowEnergy=0; PeakEnergy=0 when the macro is defined.
- Gapped valid: toggle SampleValid/MagValid randomly at 50% through the detection scenario → identical Detected sample index. EnergyEnable mirrors SampleValid while Busy.
